sfifo_wr_arb: RTL
=================

# sfifo_wr_arb

Round-robin, packet-atomic write arbiter that lets NUM_REQ requesters share the write port of one synchronous FIFO. Each requester presents a valid/ready stream with an end-of-packet marker. The arbiter grants one requester at a time and holds the grant until that requester's packet ends, so packets never interleave in the FIFO. It sits between the housekeeper's producer blocks and the FIFO's Wen/WData/Full port.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, FIFO word width
- MAX_BEATS, 16, longest legal packet in beats (≥2)

Ports:
- Clk  in  1  clock; all logic on rising edge
- ARst  in  1  reset, asynchronous, active-high
- ReqValid  in  NUM_REQ  per-requester beat valid
- ReqData  in  NUM_REQ*DATA_WIDTH  per-requester data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- ReqLast  in  NUM_REQ  final beat of packet
- ReqReady  out  NUM_REQ  beat accepted this cycle when Valid & Ready
- FifoWen  out  1  FIFO write enable
- FifoWData  out  DATA_WIDTH  FIFO write data
- FifoFull  in  1  FIFO full; must be a registered signal
- Grant  out  NUM_REQ  one-hot current owner; zero when idle
- PktDone  out  1  one-cycle pulse when a packet ends normally
- PktErr  out  1  one-cycle pulse on a forced release (MAX_BEATS reached)

## Operation
- State machine: IDLE and XFER.
- IDLE:
  - Grant = 0.
  - If any ReqValid bit is set, pick the winner: search from ptr upward, modulo NUM_REQ, and take the first set bit.
  - Register one-hot Grant and move to XFER.
  - No beat is accepted in IDLE.
- XFER:
  - ReqReady[g] = Grant[g] & ~FifoFull. All other ReqReady bits are 0.
  - FifoWen = ReqValid[g] & ReqReady[g]. FifoWData = ReqData[g] (combinational mux).
  - beat counter increments on every accepted beat.
- Packet end, on an accepted beat with ReqLast[g]=1:
  - Pulse PktDone.
  - Clear Grant and beat counter.
  - Set ptr = (g+1) mod NUM_REQ.
  - Return to IDLE.
- Forced release, on an accepted beat where the counter reaches MAX_BEATS and ReqLast=0:
  - Same actions as packet end, but pulse PktErr instead of PktDone.
  - The requester's following beats are arbitrated as a new packet.
- A requester that deasserts ReqValid mid-packet keeps the grant; the arbiter waits indefinitely.
- FifoFull stalls the transfer: ReqReady=0 and FifoWen=0. Grant and counter hold.
- Beat counter width is clog2(MAX_BEATS+1). It never wraps.
- ptr resets to 0, so requester 0 has first priority after reset.

## Timing
- Reset values: state IDLE, Grant=0, ptr=0, counter=0, PktDone=0, PktErr=0.
- Consequences of reset: ReqReady=0 and FifoWen=0. FifoWData is don't-care.
- Arbitration latency is 1 cycle. ReqValid rising in IDLE → Grant in the next cycle → first beat may be accepted in that same cycle.
- Throughput is one beat per cycle within a packet while FifoFull=0.
- Each packet costs exactly one IDLE bubble cycle, including back-to-back packets from the same requester.
- Single-beat packet (ReqLast on first beat): Grant lasts 1 cycle.
- There is no combinational path from FifoFull to FifoWen beyond the grant AND. The FIFO's Full is registered, so no loop exists.
- FifoFull is sampled each cycle. A beat written on the cycle the FIFO becomes full is legal; FifoFull rises the next cycle and blocks further beats.
- PktDone and PktErr are registered, asserted the cycle after the final accepted beat, and never both high.
- ARst mid-packet:
  - Drop the grant immediately (asynchronous). The partial packet already in the FIFO is not recalled.
  - After release, behave exactly as from power-up.

## Structure
- Shared package holds:
  - the state enum (IDLE/XFER)
  - localparams for counter width (clog2(MAX_BEATS+1)) and pointer width (clog2(NUM_REQ))
- Natural sub-module: rr_pick.
  - Purely combinational rotating priority encoder.
  - Inputs: request vector and ptr. Outputs: one-hot winner and any_req.
  - Reused by other housekeeper arbiters.
- The FIFO is instantiated by the parent, not inside this block.

## Test plan
- Single packet: requester 1 sends 3 beats 0xA0..0xA2, Last on 0xA2 → Grant=4'b0010 on the cycle after Valid; FIFO receives 0xA0,0xA1,0xA2 on consecutive cycles; PktDone pulses once; ptr=2.
- Contention: requesters 0 and 2 both valid, each sending 2-beat packets, from reset → order is 0 then 2; one idle cycle between packets; no interleaving.
- Fairness: all 4 requesters continuously send 1-beat packets → grants cycle 0,1,2,3,0,…; each requester wins every 8 cycles.
- Backpressure: hold FifoFull=1 for 5 cycles mid-packet → ReqReady=0 and FifoWen=0 for those cycles; Grant holds; transfer resumes with the next beat unmodified.
- Overlong packet: MAX_BEATS=16, requester 3 streams 20 beats with no Last → 16 beats written, PktErr pulses; after one idle cycle, remaining beats are re-arbitrated as a new packet.
- Reset mid-packet: assert ARst after beat 2 of 4 → Grant=0 and ReqReady=0 immediately; after release, requester 0 has priority (ptr=0).

Source files
------------

// File: rtl/sfifo_wr_arb_pkg.sv
// Shared types and sizing helpers for the packet-atomic FIFO write arbiter.
// Widths are derived from the parameters through the helper functions below.
package sfifo_wr_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } sfa_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_MAX_BEATS  = 16;

    localparam int unsigned CNT_W = $clog2(DEF_MAX_BEATS + 1);
    localparam int unsigned PTR_W = $clog2(DEF_NUM_REQ);

    function automatic int unsigned cnt_width(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/sfifo_wr_arb_if.sv
// Requester streams plus FIFO write port and status, bundled for the arbiter.
// Handshake: a beat on requester i transfers on a rising Clk edge where ReqValid[i] & ReqReady[i];
// ReqData/ReqLast must hold while ReqValid is high and unaccepted; ReqReady never depends on ReqValid.
interface sfifo_wr_arb_if
    import sfifo_wr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            ReqValid;
    logic [NUM_REQ*DATA_WIDTH-1:0] ReqData;
    logic [NUM_REQ-1:0]            ReqLast;
    logic [NUM_REQ-1:0]            ReqReady;
    logic                          FifoWen;
    logic [DATA_WIDTH-1:0]         FifoWData;
    logic                          FifoFull;
    logic [NUM_REQ-1:0]            Grant;
    logic                          PktDone;
    logic                          PktErr;

    modport master (
        input  ReqValid, ReqData, ReqLast, FifoFull,
        output ReqReady, FifoWen, FifoWData, Grant, PktDone, PktErr
    );

    modport slave (
        output ReqValid, ReqData, ReqLast, FifoFull,
        input  ReqReady, FifoWen, FifoWData, Grant, PktDone, PktErr
    );
endinterface

// File: rtl/sfifo_wr_arb_rr_pick.sv
// Combinational rotating priority encoder: first set request at or above ptr, wrapping.
// Rotate right by ptr, isolate lowest set bit, rotate back left by ptr.
module sfifo_wr_arb_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          any_req_o
);
    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] rot_req;
    logic [N-1:0]   low_req;
    logic [N-1:0]   low_pick;
    logic [2*N-1:0] dbl_pick;

    always_comb begin
        dbl_req   = {req_i, req_i};
        rot_req   = dbl_req >> ptr_i;
        low_req   = rot_req[N-1:0];
        low_pick  = low_req & (~low_req + {{(N-1){1'b0}}, 1'b1});
        dbl_pick  = {low_pick, low_pick} << ptr_i;
        gnt_o     = dbl_pick[2*N-1:N];
        any_req_o = |req_i;
    end
endmodule

// File: rtl/sfifo_wr_arb.sv
// Round-robin, packet-atomic arbiter sharing one FIFO write port among NUM_REQ streams.
// A grant is held until the owner's last beat, or until MAX_BEATS beats force a release.
module sfifo_wr_arb
    import sfifo_wr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_BEATS  = DEF_MAX_BEATS
) (
    input  logic                              Clk,
    input  logic                              ARst,
    sfifo_wr_arb_if.master                    bus,
    output sfa_state_e                        dbg_state_o,
    output logic [ptr_width(NUM_REQ)-1:0]     dbg_ptr_o
);
    localparam int unsigned CntW = cnt_width(MAX_BEATS);
    localparam int unsigned PtrW = ptr_width(NUM_REQ);

    sfa_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]    pick;
    logic                  any_req;
    logic [NUM_REQ-1:0]    ready;
    logic                  accept;
    logic                  g_last;
    logic [PtrW-1:0]       gidx;
    logic [PtrW-1:0]       ptr_next;
    logic [CntW-1:0]       cnt_inc;
    logic [DATA_WIDTH-1:0] wdata;

    sfifo_wr_arb_rr_pick #(
        .N  (NUM_REQ),
        .PW (PtrW)
    ) u_pick (
        .req_i     (bus.ReqValid),
        .ptr_i     (ptr_q),
        .gnt_o     (pick),
        .any_req_o (any_req)
    );

    // Owner-side datapath; the grant is one-hot so an OR-mux is sufficient.
    always_comb begin
        gidx  = '0;
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                gidx  = PtrW'(i);
                wdata = wdata | bus.ReqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ready    = ((state_q == ST_XFER) && !bus.FifoFull) ? grant_q : '0;
        accept   = |(ready & bus.ReqValid);
        g_last   = |(bus.ReqLast & grant_q);
        cnt_inc  = cnt_q + CntW'(1);
        ptr_next = (gidx == PtrW'(NUM_REQ - 1)) ? '0 : gidx + PtrW'(1);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    if (g_last || (cnt_inc == CntW'(MAX_BEATS))) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                        ptr_d   = ptr_next;
                        done_d  = g_last;
                        err_d   = ~g_last;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.ReqReady  = ready;
    assign bus.FifoWen   = accept;
    assign bus.FifoWData = wdata;
    assign bus.Grant     = grant_q;
    assign bus.PktDone   = done_q;
    assign bus.PktErr    = err_q;
    assign dbg_state_o   = state_q;
    assign dbg_ptr_o     = ptr_q;
endmodule
